// File: rtl/rot_pkg.sv
// ============================================================================
// rot_pkg : opcodes and FSM state encoding shared by the rotate sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rot_pkg;

  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rot_rr_arbiter.sv
// ============================================================================
// rot_rr_arbiter : 2-way round-robin grant; pointer moves on every accept.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rot_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_q;

  always_comb begin
    grant_o    = 2'b00;
    grant_id_o = 1'b0;
    if (en_i) begin
      case (req_i)
        2'b01: begin
          grant_o    = 2'b01;
          grant_id_o = 1'b0;
        end
        2'b10: begin
          grant_o    = 2'b10;
          grant_id_o = 1'b1;
        end
        2'b11: begin
          grant_id_o = ~last_q;
          grant_o    = last_q ? 2'b01 : 2'b10;
        end
        default: begin
          grant_o    = 2'b00;
          grant_id_o = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (|grant_o) begin
      last_q <= grant_id_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rotate_sequencer.sv
// ============================================================================
// rotate_sequencer : arbitrates two requesters and rotates one bit per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rotate_sequencer
  import rot_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [AMT_W-1:0] C_AMT_ONE = AMT_W'(1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [3:0]       op_q,    op_d;
  logic             id_q,    id_d;

  logic [1:0]       grant;
  logic             grant_id;
  logic             accept;
  logic [3:0]       sel_op;
  logic [AMT_W-1:0] sel_amt;
  logic [WIDTH-1:0] sel_data;
  logic             sel_rotates;

  rot_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .en_i       (state_q == ST_IDLE),
    .req_i      ({req1_valid, req0_valid}),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign sel_op      = grant_id ? req1_opcode : req0_opcode;
  assign sel_amt     = grant_id ? req1_amt    : req0_amt;
  assign sel_data    = grant_id ? req1_data   : req0_data;
  // A zero amount or a non-rotate opcode skips ROTATE and answers next cycle.
  assign sel_rotates = ((sel_op == OP_ROL) || (sel_op == OP_ROR)) && (sel_amt != '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    op_d    = op_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = sel_op;
          data_d  = sel_data;
          id_d    = grant_id;
          count_d = sel_rotates ? sel_amt : '0;
          state_d = sel_rotates ? ST_ROTATE : ST_RESP;
        end
      end
      ST_ROTATE: begin
        if (op_q == OP_ROL) begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        end else begin
          data_d = {data_q[0], data_q[WIDTH-1:1]};
        end
        count_d = count_q - C_AMT_ONE;
        if (count_q == C_AMT_ONE) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      op_q    <= op_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
// ============================================================================
// tb_rotate_sequencer : directed checks of arbitration, rotate latency, reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rotate_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]       req0_opcode, req1_opcode;
  logic [AMT_W-1:0] req0_amt, req1_amt;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [WIDTH-1:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;

  rotate_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_amt    (req0_amt),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_amt    (req1_amt),
    .req1_data   (req1_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request from a single requester and wait for its response.
  task automatic do_req(input logic id, input logic [3:0] op, input logic [AMT_W-1:0] amt,
                        input logic [WIDTH-1:0] d, input int exp_lat,
                        input logic [WIDTH-1:0] exp_d, input string tag);
    int k;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_opcode = op; req1_amt = amt; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_amt = amt; req0_data = d;
    end
    #1;
    check({tag, "_ready"},       32'(id ? req1_ready : req0_ready), 32'd1);
    check({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 40);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_data"},    32'(rsp_data), 32'(exp_d));
    check({tag, "_id"},      32'(rsp_id), 32'(id));
    check({tag, "_busy"},    32'(busy), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    logic             g    [4];
    logic             rid  [4];
    logic [WIDTH-1:0] rdat [4];
    logic [WIDTH-1:0] alt_exp [2];
    int  ngr, nrsp, k;
    logic both_seen, late_rsp, late_busy;

    reset = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_opcode = '0; req0_amt = '0; req0_data = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_amt = '0; req1_data = '0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset = 1'b0;

    // Single-requester operations, hand-computed results
    do_req(1'b0, 4'd10, 4'd8,  16'h00F0, 9,  16'hF000, "rol8");
    do_req(1'b1, 4'd11, 4'd1,  16'h0001, 2,  16'h8000, "ror1");
    do_req(1'b0, 4'd0,  4'd5,  16'hA5A5, 1,  16'hA5A5, "pass");
    do_req(1'b0, 4'd10, 4'd15, 16'h8001, 16, 16'hC000, "rol15");
    do_req(1'b1, 4'd11, 4'd4,  16'h1234, 5,  16'h4123, "ror4");
    do_req(1'b1, 4'd11, 4'd0,  16'h1234, 1,  16'h1234, "ror0");

    // Both requesters valid continuously: last grant was 1, so 0,1,0,1 follows
    alt_exp[0] = 16'h0004;
    alt_exp[1] = 16'h0400;
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'd10; req0_amt = 4'd2; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_opcode = 4'd10; req1_amt = 4'd2; req1_data = 16'h0100;
    ngr = 0; nrsp = 0; both_seen = 1'b0;
    for (int cyc = 0; cyc < 100 && nrsp < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_seen = 1'b1;
      if (req0_ready || req1_ready) begin
        if (ngr < 4) g[ngr] = req1_ready;
        ngr++;
        if (ngr == 4) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        rid[nrsp]  = rsp_id;
        rdat[nrsp] = rsp_data;
        nrsp++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("alt_never_both_ready", 32'(both_seen), 32'd0);
    check("alt_grant_count",      32'(ngr),  32'd4);
    check("alt_rsp_count",        32'(nrsp), 32'd4);
    for (int i = 0; i < 4 && i < nrsp && i < ngr; i++) begin
      check($sformatf("alt_grant%0d", i), 32'(g[i]),    32'(i % 2));
      check($sformatf("alt_id%0d", i),    32'(rid[i]),  32'(i % 2));
      check($sformatf("alt_data%0d", i),  32'(rdat[i]), 32'(alt_exp[i % 2]));
    end

    // Back-pressure: response held stable while rsp_ready stays low
    @(negedge clk);
    req1_valid = 1'b1; req1_opcode = 4'd10; req1_amt = 4'd1; req1_data = 16'h1234;
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_opcode = 4'd11; req0_amt = 4'd3; req0_data = 16'hFFFF;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 40);
    check("hold_latency", 32'(k), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid%0d", i),  32'(rsp_valid),  32'd1);
      check($sformatf("hold_data%0d", i),   32'(rsp_data),   32'h2468);
      check($sformatf("hold_id%0d", i),     32'(rsp_id),     32'd1);
      check($sformatf("hold_ready0_%0d", i), 32'(req0_ready), 32'd0);
      check($sformatf("hold_ready1_%0d", i), 32'(req1_ready), 32'd0);
      check($sformatf("hold_busy%0d", i),   32'(busy),       32'd1);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_release_busy", 32'(busy), 32'd0);

    // Reset mid-rotate: req0 granted last so a stale pointer would favour req1
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'd10; req0_amt = 4'd8; req0_data = 16'h00F0;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrot_busy", 32'(busy),     32'd1);
    check("midrot_data", 32'(rsp_data), 32'h03C0);
    #1;
    reset = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data",  32'(rsp_data),  32'd0);
    check("arst_rsp_id",    32'(rsp_id),    32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    late_rsp = 1'b0;
    late_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) late_rsp = 1'b1;
      if (busy) late_busy = 1'b1;
    end
    check("post_rst_no_rsp",  32'(late_rsp),  32'd0);
    check("post_rst_no_busy", 32'(late_busy), 32'd0);
    req0_valid = 1'b1; req0_opcode = 4'd0; req0_amt = 4'd0; req0_data = 16'h5A5A;
    req1_valid = 1'b1; req1_opcode = 4'd0; req1_amt = 4'd0; req1_data = 16'h0F0F;
    #1;
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_rsp_id",    32'(rsp_id),    32'd0);
    check("post_rst_rsp_data",  32'(rsp_data),  32'h5A5A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
